// File: rtl/control_teclado.sv
// Keypad controller: debounces raw scanner codes into single-cycle key events,
// accumulates decimal digits into a BCD entry and commits it on ENTER.
module control_teclado #(
    parameter int unsigned SCAN_WINDOW  = 8,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned N_DIGITS     = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    boton,
    output logic                          key_valid,
    output logic [3:0]                    key_code,
    output logic [4*N_DIGITS-1:0]         entry_bcd,
    output logic [$clog2(N_DIGITS+1)-1:0] entry_count,
    output logic                          entry_full,
    output logic [4*N_DIGITS-1:0]         value_bcd,
    output logic                          value_valid
);
    localparam int unsigned GW = $clog2(SCAN_WINDOW + 1);
    localparam int unsigned SW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned CW = $clog2(N_DIGITS + 1);
    localparam int unsigned EW = 4 * N_DIGITS;

    typedef enum logic [1:0] {StIdle, StDebounce, StPressed} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [3:0]    cand_q, cand_d;
    logic          kv_q, kv_d;
    logic [3:0]    kc_q, kc_d;
    logic [EW-1:0] entry_q, entry_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] value_q, value_d;
    logic          vv_q, vv_d;
    logic          is_f;
    logic          released;

    assign is_f = (boton == 4'hF);

    always_comb begin
        gap_d = gap_q;
        if (!is_f) begin
            gap_d = '0;
        end else if (gap_q < GW'(SCAN_WINDOW)) begin
            gap_d = gap_q + GW'(1);
        end
    end

    // The key is gone once the gap counter saturates on this edge.
    assign released = (gap_d == GW'(SCAN_WINDOW));

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        kv_d    = 1'b0;
        kc_d    = kc_q;
        unique case (state_q)
            StIdle: begin
                if (!is_f) begin
                    state_d = StDebounce;
                    cand_d  = boton;
                    stab_d  = SW'(1);
                end
            end
            StDebounce: begin
                if (!is_f && boton != cand_q) begin
                    cand_d = boton;
                    stab_d = SW'(1);
                end else if (is_f && released) begin
                    state_d = StIdle;
                    cand_d  = 4'hF;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + SW'(1);
                    // Accept on the edge where the count reaches the threshold.
                    if (stab_d == SW'(DEBOUNCE_CYC)) begin
                        state_d = StPressed;
                        kv_d    = 1'b1;
                        kc_d    = cand_q;
                    end
                end
            end
            StPressed: begin
                if (released) begin
                    state_d = StIdle;
                    cand_d  = 4'hF;
                    stab_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cand_d  = 4'hF;
                stab_d  = '0;
            end
        endcase
    end

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        value_d = value_q;
        vv_d    = 1'b0;
        if (kv_q) begin
            if (kc_q <= 4'd9) begin
                if (count_q < CW'(N_DIGITS)) begin
                    entry_d = (entry_q << 4) | EW'(kc_q);
                    count_d = count_q + CW'(1);
                end
            end else if (kc_q == 4'hE) begin
                entry_d = '0;
                count_d = '0;
            end else if (kc_q == 4'hA && count_q != '0) begin
                value_d = entry_q;
                vv_d    = 1'b1;
                entry_d = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gap_q   <= '0;
            stab_q  <= '0;
            cand_q  <= 4'hF;
            kv_q    <= 1'b0;
            kc_q    <= '0;
            entry_q <= '0;
            count_q <= '0;
            value_q <= '0;
            vv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            stab_q  <= stab_d;
            cand_q  <= cand_d;
            kv_q    <= kv_d;
            kc_q    <= kc_d;
            entry_q <= entry_d;
            count_q <= count_d;
            value_q <= value_d;
            vv_q    <= vv_d;
        end
    end

    assign key_valid   = kv_q;
    assign key_code    = kc_q;
    assign entry_bcd   = entry_q;
    assign entry_count = count_q;
    assign entry_full  = (count_q == CW'(N_DIGITS));
    assign value_bcd   = value_q;
    assign value_valid = vv_q;

endmodule

// File: tb/tb_control_teclado.sv
// Directed bench for control_teclado with DEBOUNCE_CYC=4, SCAN_WINDOW=8, N_DIGITS=3.
module tb_control_teclado;
    logic        clk;
    logic        rst_n;
    logic [3:0]  boton;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [11:0] entry_bcd;
    logic [1:0]  entry_count;
    logic        entry_full;
    logic [11:0] value_bcd;
    logic        value_valid;

    int checks = 0;
    int errors = 0;
    int kv_cnt = 0;
    int vv_cnt = 0;
    int overlap_cnt = 0;
    int vv_long_cnt = 0;
    logic vv_prev = 1'b0;

    control_teclado #(
        .SCAN_WINDOW (8),
        .DEBOUNCE_CYC(4),
        .N_DIGITS    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .boton      (boton),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .entry_bcd  (entry_bcd),
        .entry_count(entry_count),
        .entry_full (entry_full),
        .value_bcd  (value_bcd),
        .value_valid(value_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) kv_cnt++;
            if (value_valid) vv_cnt++;
            if (key_valid && value_valid) overlap_cnt++;
            if (value_valid && vv_prev) vv_long_cnt++;
        end
        vv_prev = value_valid;
    end

    task automatic step(input logic [3:0] b);
        boton = b;
        @(posedge clk);
        #1;
    endtask

    // Scanner-style press (k,F,F,F x3) followed by a full release.
    task automatic press(input logic [3:0] k);
        for (int r = 0; r < 3; r++) begin
            step(k);
            step(4'hF);
            step(4'hF);
            step(4'hF);
        end
        for (int i = 0; i < 12; i++) step(4'hF);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        boton = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({key_valid, key_code, entry_bcd, entry_count, entry_full, value_bcd, value_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs kv=%b kc=%h entry=%h cnt=%0d full=%b val=%h vv=%b",
                     key_valid, key_code, entry_bcd, entry_count, entry_full, value_bcd, value_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(4'hF);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle key_valid got %b want 0", key_valid);
        end
    endtask

    task automatic test_single_key;
        int kv0;
        kv0 = kv_cnt;
        step(4'h5);
        step(4'hF);
        step(4'hF);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early key_valid got %b want 0", key_valid);
        end
        step(4'hF);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h5) begin
            errors++;
            $display("FAIL single_event kv=%b kc=%h want kv=1 kc=5", key_valid, key_code);
        end
        step(4'h5);
        checks++;
        if (key_valid !== 1'b0 || entry_bcd !== 12'h005 || entry_count !== 2'd1) begin
            errors++;
            $display("FAIL single_entry kv=%b entry=%h cnt=%0d want 0/005/1",
                     key_valid, entry_bcd, entry_count);
        end
        for (int r = 0; r < 2; r++) begin
            step(4'hF);
            step(4'hF);
            step(4'hF);
            step(4'h5);
        end
        for (int i = 0; i < 12; i++) step(4'hF);
        checks++;
        if (kv_cnt - kv0 !== 1 || key_code !== 4'h5) begin
            errors++;
            $display("FAIL single_count events got %0d want 1 kc=%h", kv_cnt - kv0, key_code);
        end
    endtask

    task automatic test_bounce;
        int kv0;
        kv0 = kv_cnt;
        step(4'h3);
        step(4'h7);
        step(4'h3);
        step(4'h7);
        step(4'h7);
        step(4'h7);
        checks++;
        if (key_valid !== 1'b0 || kv_cnt != kv0) begin
            errors++;
            $display("FAIL bounce_early kv=%b events=%0d want 0/0", key_valid, kv_cnt - kv0);
        end
        step(4'h7);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h7) begin
            errors++;
            $display("FAIL bounce_event kv=%b kc=%h want 1/7", key_valid, key_code);
        end
        for (int i = 0; i < 6; i++) step(4'h7);
        for (int i = 0; i < 12; i++) step(4'hF);
        checks++;
        if (kv_cnt - kv0 !== 1 || entry_bcd !== 12'h057) begin
            errors++;
            $display("FAIL bounce_count events=%0d entry=%h want 1/057", kv_cnt - kv0, entry_bcd);
        end
    endtask

    task automatic test_full;
        int kv0;
        press(4'hE);
        kv0 = kv_cnt;
        press(4'h1);
        press(4'h2);
        press(4'h3);
        checks++;
        if (entry_bcd !== 12'h123 || entry_count !== 2'd3 || entry_full !== 1'b1) begin
            errors++;
            $display("FAIL full_three entry=%h cnt=%0d full=%b want 123/3/1",
                     entry_bcd, entry_count, entry_full);
        end
        press(4'h4);
        checks++;
        if (entry_bcd !== 12'h123 || entry_full !== 1'b1 || kv_cnt - kv0 !== 4) begin
            errors++;
            $display("FAIL full_drop entry=%h full=%b events=%0d want 123/1/4",
                     entry_bcd, entry_full, kv_cnt - kv0);
        end
    endtask

    task automatic test_enter;
        int vv0;
        press(4'hE);
        press(4'h4);
        press(4'h2);
        vv0 = vv_cnt;
        press(4'hA);
        checks++;
        if (vv_cnt - vv0 !== 1 || value_bcd !== 12'h042 || entry_count !== 2'd0 || entry_bcd !== 12'h000) begin
            errors++;
            $display("FAIL enter_commit pulses=%0d val=%h cnt=%0d entry=%h want 1/042/0/000",
                     vv_cnt - vv0, value_bcd, entry_count, entry_bcd);
        end
        vv0 = vv_cnt;
        press(4'hA);
        checks++;
        if (vv_cnt != vv0 || value_bcd !== 12'h042) begin
            errors++;
            $display("FAIL enter_empty pulses=%0d val=%h want 0/042", vv_cnt - vv0, value_bcd);
        end
    endtask

    task automatic test_clear_and_func;
        int kv0;
        press(4'h9);
        checks++;
        if (entry_bcd !== 12'h009 || entry_count !== 2'd1) begin
            errors++;
            $display("FAIL clear_pre entry=%h cnt=%0d want 009/1", entry_bcd, entry_count);
        end
        press(4'hE);
        checks++;
        if (entry_bcd !== 12'h000 || entry_count !== 2'd0) begin
            errors++;
            $display("FAIL clear_star entry=%h cnt=%0d want 000/0", entry_bcd, entry_count);
        end
        press(4'h1);
        kv0 = kv_cnt;
        press(4'hB);
        checks++;
        if (key_code !== 4'hB) begin
            errors++;
            $display("FAIL func_code_b kc=%h want b", key_code);
        end
        press(4'hD);
        checks++;
        if (kv_cnt - kv0 !== 2 || key_code !== 4'hD || entry_bcd !== 12'h001 || entry_count !== 2'd1) begin
            errors++;
            $display("FAIL func_keys events=%0d kc=%h entry=%h cnt=%0d want 2/d/001/1",
                     kv_cnt - kv0, key_code, entry_bcd, entry_count);
        end
    endtask

    task automatic test_reset_mid;
        int kv0;
        press(4'hE);
        press(4'h1);
        press(4'h2);
        checks++;
        if (entry_bcd !== 12'h012) begin
            errors++;
            $display("FAIL mid_setup entry=%h want 012", entry_bcd);
        end
        step(4'h8);
        step(4'h8);
        #2;
        rst_n = 1'b0;
        boton = 4'hF;
        #1;
        checks++;
        if ({key_valid, key_code, entry_bcd, entry_count, entry_full, value_bcd, value_valid} !== '0) begin
            errors++;
            $display("FAIL mid_reset kv=%b kc=%h entry=%h cnt=%0d full=%b val=%h vv=%b",
                     key_valid, key_code, entry_bcd, entry_count, entry_full, value_bcd, value_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        kv0 = kv_cnt;
        for (int i = 0; i < 20; i++) step(4'hF);
        checks++;
        if (kv_cnt != kv0 || entry_count !== 2'd0) begin
            errors++;
            $display("FAIL mid_no_event events=%0d cnt=%0d want 0/0", kv_cnt - kv0, entry_count);
        end
        press(4'h6);
        checks++;
        if (kv_cnt - kv0 !== 1 || entry_bcd !== 12'h006) begin
            errors++;
            $display("FAIL mid_fresh events=%0d entry=%h want 1/006", kv_cnt - kv0, entry_bcd);
        end
    endtask

    task automatic test_pulse_rules;
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL pulse_overlap got %0d want 0", overlap_cnt);
        end
        checks++;
        if (vv_long_cnt != 0) begin
            errors++;
            $display("FAIL value_valid_width got %0d long cycles want 0", vv_long_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        boton = 4'hF;
        test_reset();
        test_single_key();
        test_bounce();
        test_full();
        test_enter();
        test_clear_and_func();
        test_reset_mid();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
